// File: rtl/mem_responder.sv
// mem_responder: word-organised memory serving fetch and load/store accesses.
// Every accepted read returns after a fixed READ_LATENCY cycles, and the block
// takes one request per cycle. A misaligned or out-of-range request is not
// performed; instead it raises a one-cycle Error pulse.
module mem_responder #(
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Req,
  input  logic        MemReadWrite,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        DataValid,
  output logic        Error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LAT   = READ_LATENCY;

  // Array contents have no reset and are undefined at power-up.
  logic [31:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic                  aligned;
  logic                  in_range;
  logic                  rd_ok;
  logic                  wr_ok;

  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] vld_d;
  logic [31:0]    data_q [LAT];
  logic [31:0]    data_d [LAT];
  logic           error_q;
  logic           error_d;

  // Decode the request and decide whether it is accepted or rejected.
  always_comb begin
    idx      = Address[ADDR_WIDTH+1:2];
    aligned  = (Address[1:0] == 2'b00);
    in_range = ((Address >> (ADDR_WIDTH + 2)) == 32'd0);
    rd_ok    = Req && aligned && in_range && !MemReadWrite;
    wr_ok    = Req && aligned && in_range &&  MemReadWrite;
    error_d  = Req && !(aligned && in_range);
  end

  // Advance the read pipeline. A bubble moves the valid bit along but leaves
  // the data in place, so DataOut keeps the last read result.
  always_comb begin
    vld_d = '0;
    for (int k = 0; k < LAT; k++) begin
      data_d[k] = data_q[k];
    end
    vld_d[0] = rd_ok;
    if (rd_ok) begin
      data_d[0] = mem[idx];
    end
    for (int k = 1; k < LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        data_d[k] = data_q[k-1];
      end
    end
  end

  // Pipeline and error registers. Reset clears them at once and drops any
  // reads still in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q   <= '0;
      error_q <= 1'b0;
      for (int k = 0; k < LAT; k++) begin
        data_q[k] <= 32'h0;
      end
    end else begin
      vld_q   <= vld_d;
      error_q <= error_d;
      for (int k = 0; k < LAT; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  // Array write. The read for stage 0 is taken from the pre-edge contents, so
  // a write on the following edge cannot disturb a read already in flight.
  always_ff @(posedge clock) begin
    if (wr_ok && !reset) begin
      mem[idx] <= DataIn;
    end
  end

  assign DataOut   = data_q[LAT-1];
  assign DataValid = vld_q[LAT-1];
  assign Error     = error_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder. Three builds (latency 1, 2 and 4)
// receive identical stimulus; each step checks them against hand-worked values.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        Req = 1'b0;
  logic        MemReadWrite = 1'b0;
  logic [31:0] Address = 32'h0;
  logic [31:0] DataIn = 32'h0;

  logic [31:0] do1, do2, do4;
  logic        dv1, dv2, dv4;
  logic        er1, er2, er4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_responder #(.ADDR_WIDTH(8), .READ_LATENCY(1)) u1 (
    .clock(clock), .reset(reset), .Req(Req), .MemReadWrite(MemReadWrite),
    .Address(Address), .DataIn(DataIn), .DataOut(do1), .DataValid(dv1), .Error(er1));
  mem_responder #(.ADDR_WIDTH(8), .READ_LATENCY(2)) u2 (
    .clock(clock), .reset(reset), .Req(Req), .MemReadWrite(MemReadWrite),
    .Address(Address), .DataIn(DataIn), .DataOut(do2), .DataValid(dv2), .Error(er2));
  mem_responder #(.ADDR_WIDTH(8), .READ_LATENCY(4)) u4 (
    .clock(clock), .reset(reset), .Req(Req), .MemReadWrite(MemReadWrite),
    .Address(Address), .DataIn(DataIn), .DataOut(do4), .DataValid(dv4), .Error(er4));

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one request during a cycle, then step to 1 time unit past the edge
  // that samples it.
  task automatic cyc(input logic req, input logic rw, input logic [31:0] addr,
                     input logic [31:0] din);
    @(negedge clock);
    Req          = req;
    MemReadWrite = rw;
    Address      = addr;
    DataIn       = din;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(posedge clock);
    #1;
    chk32("rst_do2", do2, 32'h0);
    chk1("rst_dv2", dv2, 1'b0);
    chk1("rst_er2", er2, 1'b0);
    chk1("rst_dv1", dv1, 1'b0);
    chk1("rst_dv4", dv4, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Write then read 0x10
    cyc(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    chk1("wr_er2", er2, 1'b0);
    chk1("wr_dv2", dv2, 1'b0);
    cyc(1'b1, 1'b0, 32'h10, 32'h0);            // read issued, now cycle n+1
    chk1("l1_dv", dv1, 1'b1);
    chk32("l1_do", do1, 32'hDEADBEEF);
    chk1("l2_dv_early", dv2, 1'b0);
    chk1("rd_er2", er2, 1'b0);
    idle();                                    // cycle n+2
    chk1("l2_dv", dv2, 1'b1);
    chk32("l2_do", do2, 32'hDEADBEEF);
    chk1("l1_dv_drop", dv1, 1'b0);
    chk32("l1_do_hold", do1, 32'hDEADBEEF);
    idle();                                    // cycle n+3
    chk1("l4_dv_early", dv4, 1'b0);
    chk1("l2_dv_drop", dv2, 1'b0);
    idle();                                    // cycle n+4
    chk1("l4_dv", dv4, 1'b1);
    chk32("l4_do", do4, 32'hDEADBEEF);
    chk32("l2_do_hold", do2, 32'hDEADBEEF);

    // Back-to-back reads of 1, 2, 3
    cyc(1'b1, 1'b1, 32'h0, 32'd1);
    cyc(1'b1, 1'b1, 32'h4, 32'd2);
    cyc(1'b1, 1'b1, 32'h8, 32'd3);
    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h4, 32'h0);
    chk1("b2b_dv0", dv2, 1'b1);
    chk32("b2b_do0", do2, 32'd1);
    cyc(1'b1, 1'b0, 32'h8, 32'h0);
    chk1("b2b_dv1", dv2, 1'b1);
    chk32("b2b_do1", do2, 32'd2);
    idle();
    chk1("b2b_dv2", dv2, 1'b1);
    chk32("b2b_do2", do2, 32'd3);
    idle();
    chk1("b2b_dv_end", dv2, 1'b0);
    chk32("b2b_do_hold", do2, 32'd3);

    // Write immediately after a read of the same word
    cyc(1'b1, 1'b1, 32'h20, 32'hA);
    cyc(1'b1, 1'b0, 32'h20, 32'h0);
    cyc(1'b1, 1'b1, 32'h20, 32'hB);
    chk1("war_dv", dv2, 1'b1);
    chk32("war_old", do2, 32'hA);
    cyc(1'b1, 1'b0, 32'h20, 32'h0);
    idle();
    chk1("war_dv2", dv2, 1'b1);
    chk32("war_new", do2, 32'hB);

    // Misaligned read, then out-of-range write
    cyc(1'b1, 1'b0, 32'h6, 32'h0);
    chk1("mis_er2", er2, 1'b1);
    chk1("mis_er4", er4, 1'b1);
    chk1("mis_dv1", dv1, 1'b0);
    cyc(1'b1, 1'b1, 32'h400, 32'hFFFF_FFFF);
    chk1("oor_er2", er2, 1'b1);
    chk1("mis_dv2", dv2, 1'b0);
    idle();
    chk1("err_clear", er2, 1'b0);
    chk1("oor_dv2", dv2, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h4, 32'h0);
    chk32("nocorrupt0", do2, 32'd1);
    idle();
    chk32("nocorrupt4", do2, 32'd2);
    chk1("nocorrupt_er", er2, 1'b0);

    // Reset while a read is in flight; a write is attempted during reset
    cyc(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clock);
    reset        = 1'b1;
    Req          = 1'b1;
    MemReadWrite = 1'b1;
    Address      = 32'h10;
    DataIn       = 32'h0;
    #1;
    chk1("arst_dv1", dv1, 1'b0);
    chk32("arst_do1", do1, 32'h0);
    chk32("arst_do2", do2, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    Req   = 1'b0;
    #1;
    chk1("rst_drop_dv2", dv2, 1'b0);
    idle();
    chk1("rst_drop_dv4a", dv4, 1'b0);
    idle();
    chk1("rst_drop_dv4b", dv4, 1'b0);
    chk32("rst_do2_zero", do2, 32'h0);
    cyc(1'b1, 1'b0, 32'h10, 32'h0);
    idle();
    chk1("post_rst_dv2", dv2, 1'b1);
    chk32("post_rst_do2", do2, 32'hDEADBEEF);
    idle();
    chk1("idle_dv1", dv1, 1'b0);
    chk32("idle_do1", do1, 32'hDEADBEEF);
    idle();
    chk1("post_rst_dv4", dv4, 1'b1);
    chk32("post_rst_do4", do4, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
